// File: rtl/shifter_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter_if
// Brief    : Request, shifter-control and response bundle for shifter_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface shifter_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    i_req_valid;
    logic [N_REQ-1:0]    o_req_ready;
    logic [N_REQ*32-1:0] i_req_data;
    logic [N_REQ*5-1:0]  i_req_amt;
    logic [N_REQ-1:0]    i_req_signed;
    logic [N_REQ-1:0]    i_req_left;

    logic [31:0]         o_sh_data;
    logic [4:0]          o_sh_amt;
    logic                o_sh_signed;
    logic                o_sh_left;
    logic                o_sh_issue;
    logic [31:0]         i_sh_result;

    logic                o_rsp_valid;
    logic [ID_W-1:0]     o_rsp_id;
    logic [31:0]         o_rsp_data;
    logic                i_rsp_ready;

    // Client side: requesters, the shifter instance and the response consumer.
    modport master (
        output i_req_valid, i_req_data, i_req_amt, i_req_signed, i_req_left,
        output i_sh_result, i_rsp_ready,
        input  o_req_ready, o_sh_data, o_sh_amt, o_sh_signed, o_sh_left,
        input  o_sh_issue, o_rsp_valid, o_rsp_id, o_rsp_data
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_amt, i_req_signed, i_req_left,
        input  i_sh_result, i_rsp_ready,
        output o_req_ready, o_sh_data, o_sh_amt, o_sh_signed, o_sh_left,
        output o_sh_issue, o_rsp_valid, o_rsp_id, o_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter
// Brief    : Round-robin sharing of one barrel shifter with an ID-tagged
//            first-word-fall-through response FIFO and credit-based issue.
// Revision : 1.0 - initial release
// ============================================================================
module shifter_arbiter #(
    parameter int N_REQ     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    shifter_arbiter_if.slave bus
);
    localparam int c_ID_W  = $clog2(N_REQ);
    localparam int c_PTR_W = $clog2(RSP_DEPTH);
    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [c_ID_W-1:0]  c_LAST_ID  = c_ID_W'(N_REQ - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RSP_DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(RSP_DEPTH);

    logic [c_ID_W-1:0]  r_ptr;
    logic [c_ID_W-1:0]  r_id_q;
    logic               r_inflight;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_mem_data [RSP_DEPTH];
    logic [c_ID_W-1:0]  r_mem_id   [RSP_DEPTH];

    logic [c_ID_W-1:0]  w_grant_id;
    logic               w_found;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [c_CNT_W:0]   w_occ;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.i_req_valid[(int'(r_ptr) + i) % N_REQ]) begin
                w_found    = 1'b1;
                w_grant_id = c_ID_W'((int'(r_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty & bus.i_rsp_ready;
    assign w_push      = r_inflight;

    // Counting the in-flight op reserves its FIFO slot before the result lands.
    assign w_occ   = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight}
                   - {{c_CNT_W{1'b0}}, w_pop};
    assign w_issue = i_rst_n & w_found & (w_occ < c_DEPTH);

    always_comb begin
        bus.o_req_ready = '0;
        bus.o_sh_data   = '0;
        bus.o_sh_amt    = '0;
        bus.o_sh_signed = 1'b0;
        bus.o_sh_left   = 1'b0;
        bus.o_sh_issue  = 1'b0;
        if (w_issue) begin
            bus.o_req_ready[w_grant_id] = 1'b1;
            bus.o_sh_data   = bus.i_req_data[32*w_grant_id +: 32];
            bus.o_sh_amt    = bus.i_req_amt[5*w_grant_id +: 5];
            bus.o_sh_signed = bus.i_req_signed[w_grant_id];
            bus.o_sh_left   = bus.i_req_left[w_grant_id];
            bus.o_sh_issue  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_id_q     <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_id_q <= w_grant_id;
                r_ptr  <= (w_grant_id == c_LAST_ID) ? '0 : w_grant_id + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.i_sh_result;
            r_mem_id[r_wr_ptr]   <= r_id_q;
        end
    end

    assign bus.o_rsp_valid = w_not_empty;
    assign bus.o_rsp_id    = w_not_empty ? r_mem_id[r_rd_ptr]   : '0;
    assign bus.o_rsp_data  = w_not_empty ? r_mem_data[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_arbiter
// Brief    : Directed self-checking bench for shifter_arbiter with a
//            behavioural registered barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shifter_arbiter_if #(.N_REQ(4)) bus ();

    shifter_arbiter #(.N_REQ(4), .RSP_DEPTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Shared shifter: result registered one cycle after the operands.
    always @(posedge clk) begin
        if (bus.o_sh_left)
            bus.i_sh_result <= bus.o_sh_data << bus.o_sh_amt;
        else if (bus.o_sh_signed)
            bus.i_sh_result <= $signed(bus.o_sh_data) >>> bus.o_sh_amt;
        else
            bus.i_sh_result <= bus.o_sh_data >> bus.o_sh_amt;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] a,
                           input logic s, input logic l);
        bus.i_req_data[32*k +: 32] = d;
        bus.i_req_amt[5*k +: 5]    = a;
        bus.i_req_signed[k]        = s;
        bus.i_req_left[k]          = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req_valid = 4'hF;
        bus.i_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.o_rsp_valid); end
        checks++; if (bus.o_rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.o_rsp_id); end
        checks++; if (bus.o_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.o_rsp_data); end
        checks++; if (bus.o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.o_req_ready); end
        checks++; if (bus.o_sh_issue !== 1'b0) begin errors++; $display("FAIL reset_sh_issue: got %b expected 0", bus.o_sh_issue); end
        checks++; if (bus.o_sh_data !== 32'h0) begin errors++; $display("FAIL reset_sh_data: got %h expected 0", bus.o_sh_data); end
        next_cycle();
        bus.i_req_valid = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data [4] = '{32'hA5A50000, 32'hD2D28000, 32'h29694000, 32'h2D280018};
        logic [3:0]  exp_rdy;
        set_req(0, 32'hA5A50000, 5'd0, 1'b0, 1'b0);
        set_req(1, 32'hA5A50001, 5'd1, 1'b1, 1'b0);
        set_req(2, 32'hA5A50002, 5'd2, 1'b0, 1'b0);
        set_req(3, 32'hA5A50003, 5'd3, 1'b0, 1'b1);
        bus.i_rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.i_req_valid = (c < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            checks++; if (bus.o_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, bus.o_req_ready, exp_rdy); end
            checks++; if (bus.o_rsp_valid !== (c >= 2)) begin errors++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, bus.o_rsp_valid, (c >= 2)); end
            if (c >= 2) begin
                checks++; if (bus.o_rsp_id !== 2'((c - 2) % 4)) begin errors++; $display("FAIL rr_rsp_id c=%0d: got %0d expected %0d", c, bus.o_rsp_id, (c - 2) % 4); end
                checks++; if (bus.o_rsp_data !== exp_data[(c - 2) % 4]) begin errors++; $display("FAIL rr_rsp_data c=%0d: got %h expected %h", c, bus.o_rsp_data, exp_data[(c - 2) % 4]); end
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        set_req(2, 32'h800000F0, 5'd4, 1'b1, 1'b0);
        bus.i_req_valid = 4'b0100;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.o_req_ready); end
        checks++; if (bus.o_sh_issue !== 1'b1) begin errors++; $display("FAIL single_issue: got %b expected 1", bus.o_sh_issue); end
        checks++; if ({bus.o_sh_data, bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left} !== {32'h800000F0, 5'd4, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_sh_fields: got %h/%0d/%b/%b expected 800000f0/4/1/0", bus.o_sh_data, bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left); end
        next_cycle();
        bus.i_req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (bus.o_req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop: got %b expected 0000", bus.o_req_ready); end
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early: got %b expected 0", bus.o_rsp_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", bus.o_rsp_valid); end
        checks++; if (bus.o_rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", bus.o_rsp_id); end
        checks++; if (bus.o_rsp_data !== 32'hF800000F) begin errors++; $display("FAIL single_rsp_data: got %h expected f800000f", bus.o_rsp_data); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drained: got %b expected 0", bus.o_rsp_valid); end
        next_cycle();
    endtask

    task automatic test_left();
        set_req(1, 32'h00000001, 5'd31, 1'b1, 1'b1);
        bus.i_req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus.o_req_ready !== 4'b0010) begin errors++; $display("FAIL left_ready: got %b expected 0010", bus.o_req_ready); end
        checks++; if ({bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left} !== {5'd31, 1'b1, 1'b1}) begin
            errors++; $display("FAIL left_sh_ctrl: got %0d/%b/%b expected 31/1/1", bus.o_sh_amt, bus.o_sh_signed, bus.o_sh_left); end
        next_cycle();
        bus.i_req_valid = 4'b0000;
        next_cycle();
        @(negedge clk);
        checks++; if (bus.o_rsp_id !== 2'd1) begin errors++; $display("FAIL left_rsp_id: got %0d expected 1", bus.o_rsp_id); end
        checks++; if (bus.o_rsp_data !== 32'h80000000) begin errors++; $display("FAIL left_rsp_data: got %h expected 80000000", bus.o_rsp_data); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        bit          exp_rdy [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        bit          exp_rv  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        int          exp_idx [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
        int          n = 0;
        for (int c = 0; c < 9; c++) begin
            set_req(0, 32'hB0000000 + 32'(n), 5'd0, 1'b0, 1'b0);
            bus.i_req_valid = (c < 6) ? 4'b0001 : 4'b0000;
            bus.i_rsp_ready = (c >= 4);
            @(negedge clk);
            checks++; if (bus.o_req_ready !== (exp_rdy[c] ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, bus.o_req_ready, exp_rdy[c]); end
            checks++; if (bus.o_rsp_valid !== exp_rv[c]) begin errors++; $display("FAIL bp_rsp_valid c=%0d: got %b expected %b", c, bus.o_rsp_valid, exp_rv[c]); end
            if (exp_rv[c]) begin
                checks++; if (bus.o_rsp_data !== 32'hB0000000 + 32'(exp_idx[c])) begin errors++; $display("FAIL bp_rsp_data c=%0d: got %h expected %h", c, bus.o_rsp_data, 32'hB0000000 + 32'(exp_idx[c])); end
            end
            if (exp_rdy[c]) n++;
            next_cycle();
        end
    endtask

    task automatic test_push_pop();
        bus.i_rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            set_req(3, 32'hC0000000 + 32'(c), 5'd0, 1'b0, 1'b0);
            bus.i_req_valid = (c < 6) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            checks++; if (bus.o_req_ready !== ((c < 6) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL pp_ready c=%0d: got %b", c, bus.o_req_ready); end
            checks++; if (bus.o_rsp_valid !== (c >= 2 && c < 8)) begin errors++; $display("FAIL pp_rsp_valid c=%0d: got %b expected %b", c, bus.o_rsp_valid, (c >= 2 && c < 8)); end
            if (c >= 2 && c < 8) begin
                checks++; if ({bus.o_rsp_id, bus.o_rsp_data} !== {2'd3, 32'hC0000000 + 32'(c - 2)}) begin
                    errors++; $display("FAIL pp_rsp c=%0d: got id %0d data %h expected id 3 data %h", c, bus.o_rsp_id, bus.o_rsp_data, 32'hC0000000 + 32'(c - 2)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        set_req(1, 32'h12345678, 5'd4, 1'b0, 1'b0);
        bus.i_req_valid = 4'b0010;
        bus.i_rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_req_ready !== 4'b0010) begin errors++; $display("FAIL rm_ready0: got %b expected 0010", bus.o_req_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.o_req_ready !== 4'b0010) begin errors++; $display("FAIL rm_ready1: got %b expected 0010", bus.o_req_ready); end
        next_cycle();
        bus.i_req_valid = 4'b0000;
        checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b expected 1", bus.o_rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid: got %b expected 0", bus.o_rsp_valid); end
        checks++; if (bus.o_rsp_data !== 32'h0) begin errors++; $display("FAIL rm_async_data: got %h expected 0", bus.o_rsp_data); end
        next_cycle();
        rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_stale c=%0d: got %b expected 0", c, bus.o_rsp_valid); end
            next_cycle();
        end
        set_req(0, 32'h0F0F0F0F, 5'd4, 1'b0, 1'b1);
        bus.i_req_valid = 4'hF;
        @(negedge clk);
        checks++; if (bus.o_req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b expected 0001", bus.o_req_ready); end
        next_cycle();
        bus.i_req_valid = 4'h0;
        next_cycle();
        @(negedge clk);
        checks++; if ({bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data} !== {1'b1, 2'd0, 32'hF0F0F0F0}) begin
            errors++; $display("FAIL rm_post_rsp: got %b/%0d/%h expected 1/0/f0f0f0f0", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data); end
        next_cycle();
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.i_req_valid  = '0;
        bus.i_req_data   = '0;
        bus.i_req_amt    = '0;
        bus.i_req_signed = '0;
        bus.i_req_left   = '0;
        bus.i_rsp_ready  = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_left();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one 32-bit single-cycle barrel shifter among N_REQ requesters.
- Arbitrates with a round-robin policy and drives the shifter's operand and control inputs.
- Captures each result one cycle after issue and returns it, tagged with the requester ID, through a small response FIFO that honours backpressure.
- Sits between execution-side clients and the shared shifter instance.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- RSP_DEPTH, 2, response FIFO depth; legal range 2..8.
- ID_W, $clog2(N_REQ), width of the requester ID; derived, not to be overridden.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  N_REQ  per-requester request valid.
- o_req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- i_req_data  in  N_REQ*32  operand; slice k = [32k+31:32k].
- i_req_amt  in  N_REQ*5  shift amount; slice k = [5k+4:5k].
- i_req_signed  in  N_REQ  arithmetic right shift select.
- i_req_left  in  N_REQ  left shift select; overrides signed.
- o_sh_data  out  32  shifter operand.
- o_sh_amt  out  5  shifter amount.
- o_sh_signed  out  1  shifter signed control.
- o_sh_left  out  1  shifter left control.
- o_sh_issue  out  1  high in any cycle an operation is issued.
- i_sh_result  in  32  shifter registered output; valid exactly 1 cycle after issue.
- o_rsp_valid  out  1  response available.
- o_rsp_id  out  ID_W  requester index of the response.
- o_rsp_data  out  32  shift result.
- i_rsp_ready  in  1  response consumer accept.

Behaviour:
- Reset (asynchronous assert, synchronous deassert use):
  - round-robin pointer = 0; in-flight flag = 0; FIFO empty.
  - o_rsp_valid = 0; o_rsp_id = 0; o_rsp_data = 0.
  - o_req_ready = 0; o_sh_issue = 0.
  - An operation in flight at reset is dropped; no response is ever produced for it.
- Credit check:
  - occ = FIFO count + in-flight flag − (o_rsp_valid & i_rsp_ready).
  - Issue is allowed only when occ < RSP_DEPTH. This guarantees that a captured result always finds a free FIFO slot.
- Arbitration (combinational):
  - Search from pointer p upward, modulo N_REQ, for the first set i_req_valid bit. That requester g wins.
  - With credit and a winner: o_req_ready[g] = 1, o_sh_issue = 1, and o_sh_* = requester g's fields.
  - Otherwise: o_req_ready = 0, o_sh_issue = 0, and o_sh_data/amt/signed/left are all 0.
  - At most one issue per cycle.
- Handshake rules:
  - A transfer occurs when i_req_valid[k] & o_req_ready[k].
  - Requesters hold valid and fields stable until accepted.
  - i_req_valid must not depend on o_req_ready.
- Pointer update: on issue to g, p <= (g+1) mod N_REQ. With no issue, p holds.
- Capture:
  - On issue, register in-flight <= 1 and id_q <= g; otherwise in-flight <= 0.
  - In the next cycle, if in-flight = 1, push {id_q, i_sh_result} into the FIFO.
  - Back-to-back issues therefore give one push per cycle, with 1-cycle issue-to-push latency.
- Response FIFO:
  - First-word fall-through; o_rsp_* show the head entry.
  - A push and a pop in the same cycle are both honoured and the count is unchanged.
  - Full is never reached with a push pending, because of the credit check.
  - Pointers wrap modulo RSP_DEPTH.
  - Response order equals issue order.
- Latency: accept at cycle T gives o_rsp_valid no earlier than T+2. Minimum accept-to-response is 2 cycles; throughput is 1 per cycle when i_rsp_ready is held at 1.
- Shift semantics belong entirely to the shifter. This block passes the fields through unmodified, including amt = 0.

Test Plan:
- Single request: requester 2 sends data=0x8000_00F0, amt=4, signed=1, left=0 → o_req_ready[2] high for 1 cycle; 2 cycles later o_rsp_valid=1, id=2, data=0xF800_000F.
- Round-robin fairness: all 4 valid continuously, i_rsp_ready=1 → grant order 0,1,2,3,0,1… with one issue per cycle; responses arrive in that order with no gaps.
- Backpressure: i_rsp_ready=0, RSP_DEPTH=2, requester 0 valid continuously → exactly 2 accepts, then o_req_ready=0. Raising i_rsp_ready → entries drain in order and issues resume, never exceeding 2 outstanding.
- Simultaneous push and pop: steady stream with the FIFO holding 1 entry and i_rsp_ready=1 → the count stays at 1 and no data is lost or duplicated.
- Left shift through the path: requester 1 sends data=0x0000_0001, amt=31, left=1 → response data=0x8000_0000, id=1.
- Reset mid-operation: assert i_rst_n=0 in the cycle after an issue → o_rsp_valid=0 immediately. After release, no stale response appears and the next grant starts from requester 0.
